calc_entry_sequencer: RTL

//  Sequences the two-operand hex adder on the GoBoard: operand entry, add, result display.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_entry_sequencer_if.sv | 30 +++
 rtl/blink_prescaler.sv | 35 +++
 rtl/calc_entry_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the hex-adder entry sequencer: state codes, digit
// widths and the operand adder.
package calc_pkg;

  localparam int DIGIT_W = 4;
  localparam int RES_W   = DIGIT_W + 1;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_ENTER_A = 3'd1;
  localparam logic [STATE_W-1:0] S_ENTER_B = 3'd2;
  localparam logic [STATE_W-1:0] S_ADD     = 3'd3;
  localparam logic [STATE_W-1:0] S_SHOW    = 3'd4;

  // Zero-extend both operands so the carry lands in the top result bit.
  function automatic logic [RES_W-1:0] add_operands(input logic [DIGIT_W-1:0] a,
                                                    input logic [DIGIT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// Button-pulse inputs and display/LED outputs of the entry sequencer.
interface calc_entry_sequencer_if;
  import calc_pkg::*;

  logic               i_Inc_Pulse;
  logic               i_Next_Pulse;
  logic               i_Clear_Pulse;
  logic [DIGIT_W-1:0] o_Disp_Hi;
  logic [DIGIT_W-1:0] o_Disp_Lo;
  logic               o_Blank_Hi;
  logic               o_Blank_Lo;
  logic               o_LED_A;
  logic               o_LED_B;
  logic               o_Res_Valid;
  logic               o_Overflow;
  logic [STATE_W-1:0] o_State;

  modport master (
    output i_Inc_Pulse, i_Next_Pulse, i_Clear_Pulse,
    input  o_Disp_Hi, o_Disp_Lo, o_Blank_Hi, o_Blank_Lo,
           o_LED_A, o_LED_B, o_Res_Valid, o_Overflow, o_State
  );

  modport slave (
    input  i_Inc_Pulse, i_Next_Pulse, i_Clear_Pulse,
    output o_Disp_Hi, o_Disp_Lo, o_Blank_Hi, o_Blank_Lo,
           o_LED_A, o_LED_B, o_Res_Valid, o_Overflow, o_State
  );

endinterface

// File: rtl/blink_prescaler.sv
// Square-wave phase for the operand-entry LED; restarts in the ON phase so a
// freshly entered state always begins with its LED lit.
module blink_prescaler #(
  parameter int BLINK_DIV = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Restart,
  output logic o_Phase
);

  localparam int PW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0] count;
  logic          phase;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count <= '0;
      phase <= 1'b1;
    end else if (i_Restart) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_Phase = phase;

endmodule

// File: rtl/calc_entry_sequencer.sv
// Operand-entry / add / show sequencer for the two-digit hex adder. State and
// operands form stage p0; every output is re-registered in stage p1.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int BLINK_DIV   = 12500000,
  parameter int SHOW_CYCLES = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  calc_entry_sequencer_if.slave bus
);

  logic inc, nxt, clr;
  assign inc = bus.i_Inc_Pulse;
  assign nxt = bus.i_Next_Pulse;
  assign clr = bus.i_Clear_Pulse;

  logic [STATE_W-1:0] state_p0, state_nxt;
  logic [DIGIT_W-1:0] cnt_p0, a_p0, b_p0;
  logic [RES_W-1:0]   r_p0;
  logic               blink_phase;
  logic               show_done;

  // ---- stage p0: state register ----
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_p0 <= S_IDLE;
    else          state_p0 <= state_nxt;
  end

  // Clear outranks Next, which outranks Inc; lower pulses are simply dropped.
  always_comb begin
    state_nxt = state_p0;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_p0)
        S_IDLE:    if (nxt || inc) state_nxt = S_ENTER_A;
        S_ENTER_A: if (nxt)        state_nxt = S_ENTER_B;
        S_ENTER_B: if (nxt)        state_nxt = S_ADD;
        S_ADD:                     state_nxt = S_SHOW;
        S_SHOW: begin
          if (nxt)            state_nxt = S_ENTER_A;
          else if (show_done) state_nxt = S_IDLE;
        end
        default:                   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_p0 <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      r_p0   <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      r_p0   <= '0;
    end else begin
      case (state_p0)
        S_IDLE: if (nxt || inc) cnt_p0 <= '0;
        S_ENTER_A: begin
          if (nxt) begin
            a_p0   <= cnt_p0;
            cnt_p0 <= '0;
          end else if (inc) begin
            cnt_p0 <= cnt_p0 + 1'b1;
          end
        end
        S_ENTER_B: begin
          if (nxt)      b_p0   <= cnt_p0;
          else if (inc) cnt_p0 <= cnt_p0 + 1'b1;
        end
        S_ADD:  r_p0 <= add_operands(a_p0, b_p0);
        S_SHOW: if (nxt) cnt_p0 <= '0;
        default: ;
      endcase
    end
  end

  blink_prescaler #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Restart(state_nxt != state_p0),
    .o_Phase  (blink_phase)
  );

  generate
    if (SHOW_CYCLES != 0) begin : g_show_timeout
      localparam int SW = $clog2(SHOW_CYCLES + 1);
      localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
      logic [SW-1:0] show_cnt;

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)                show_cnt <= '0;
        else if (state_p0 == S_SHOW) show_cnt <= show_cnt + 1'b1;
        else                         show_cnt <= '0;
      end

      assign show_done = (state_p0 == S_SHOW) && (show_cnt == SHOW_LAST);
    end else begin : g_no_show_timeout
      assign show_done = 1'b0;
    end
  endgenerate

  logic [DIGIT_W-1:0] disp_hi_d, disp_lo_d;
  logic               blank_hi_d, blank_lo_d, led_a_d, led_b_d, res_vld_d, ovf_d;

  always_comb begin
    disp_hi_d  = '0;
    disp_lo_d  = '0;
    blank_hi_d = 1'b1;
    blank_lo_d = 1'b1;
    led_a_d    = 1'b0;
    led_b_d    = 1'b0;
    res_vld_d  = 1'b0;
    ovf_d      = 1'b0;
    case (state_p0)
      S_ENTER_A: begin
        disp_lo_d  = cnt_p0;
        blank_lo_d = 1'b0;
        led_a_d    = blink_phase;
      end
      S_ENTER_B: begin
        disp_lo_d  = cnt_p0;
        blank_lo_d = 1'b0;
        led_a_d    = 1'b1;
        led_b_d    = blink_phase;
      end
      S_ADD: begin
        led_a_d = 1'b1;
        led_b_d = 1'b1;
      end
      S_SHOW: begin
        disp_hi_d  = {{(DIGIT_W-1){1'b0}}, r_p0[RES_W-1]};
        disp_lo_d  = r_p0[DIGIT_W-1:0];
        blank_hi_d = 1'b0;
        blank_lo_d = 1'b0;
        led_a_d    = 1'b1;
        led_b_d    = 1'b1;
        res_vld_d  = 1'b1;
        ovf_d      = r_p0[RES_W-1];
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered outputs ----
  logic [DIGIT_W-1:0] disp_hi_p1, disp_lo_p1;
  logic               blank_hi_p1, blank_lo_p1, led_a_p1, led_b_p1, res_vld_p1, ovf_p1;
  logic [STATE_W-1:0] state_p1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      disp_hi_p1  <= '0;
      disp_lo_p1  <= '0;
      blank_hi_p1 <= 1'b1;
      blank_lo_p1 <= 1'b1;
      led_a_p1    <= 1'b0;
      led_b_p1    <= 1'b0;
      res_vld_p1  <= 1'b0;
      ovf_p1      <= 1'b0;
      state_p1    <= S_IDLE;
    end else begin
      disp_hi_p1  <= disp_hi_d;
      disp_lo_p1  <= disp_lo_d;
      blank_hi_p1 <= blank_hi_d;
      blank_lo_p1 <= blank_lo_d;
      led_a_p1    <= led_a_d;
      led_b_p1    <= led_b_d;
      res_vld_p1  <= res_vld_d;
      ovf_p1      <= ovf_d;
      state_p1    <= state_p0;
    end
  end

  assign bus.o_Disp_Hi   = disp_hi_p1;
  assign bus.o_Disp_Lo   = disp_lo_p1;
  assign bus.o_Blank_Hi  = blank_hi_p1;
  assign bus.o_Blank_Lo  = blank_lo_p1;
  assign bus.o_LED_A     = led_a_p1;
  assign bus.o_LED_B     = led_b_p1;
  assign bus.o_Res_Valid = res_vld_p1;
  assign bus.o_Overflow  = ovf_p1;
  assign bus.o_State     = state_p1;

endmodule
